// File: rtl/m3_key_cmd_gen_pkg.sv
// Shared definitions for the M3 key command generator: default timing,
// key slot indices and the INC/DEC auto-repeat FSM state encoding.
package m3_pkg;

    localparam int unsigned DEF_DEBOUNCE_CYC  = 20000;
    localparam int unsigned DEF_REPEAT_DELAY  = 10000000;
    localparam int unsigned DEF_REPEAT_PERIOD = 2000000;

    // Slot order of the raw key vector inside the top level
    localparam int unsigned NUM_KEYS    = 7;
    localparam int unsigned KEY_START   = 0;
    localparam int unsigned KEY_STOP    = 1;
    localparam int unsigned KEY_DIR     = 2;
    localparam int unsigned KEY_STEP0   = 3;  // freqUp, freqDn, pwrUp, pwrDn follow
    localparam int unsigned NUM_STEP    = 4;

    // Repeat FSM states
    typedef logic [1:0] rpt_state_t;
    localparam rpt_state_t RPT_IDLE   = 2'd0;
    localparam rpt_state_t RPT_DELAY  = 2'd1;
    localparam rpt_state_t RPT_REPEAT = 2'd2;

    // Bits needed to hold the values 0..max_val
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/m3_key_cmd_gen_if.sv
// Key/command bundle of the M3 key command generator.
// slave: seen from the generator (keys in, commands out); master: the other side.
interface m3_key_cmd_gen_if;

    // Raw push-buttons, active-low, asynchronous to the clock
    logic keyStartI;
    logic keyStopI;
    logic keyDirI;
    logic keyFreqUpI;
    logic keyFreqDnI;
    logic keyPwrUpI;
    logic keyPwrDnI;

    // Motor commands
    logic m3startO;
    logic m3forceStopO;
    logic m3invRotateO;
    logic m3freqINCo;
    logic m3freqDECo;
    logic m3powerINCo;
    logic m3powerDECo;

    modport master (
        output keyStartI, keyStopI, keyDirI, keyFreqUpI, keyFreqDnI, keyPwrUpI, keyPwrDnI,
        input  m3startO, m3forceStopO, m3invRotateO,
        input  m3freqINCo, m3freqDECo, m3powerINCo, m3powerDECo
    );

    modport slave (
        input  keyStartI, keyStopI, keyDirI, keyFreqUpI, keyFreqDnI, keyPwrUpI, keyPwrDnI,
        output m3startO, m3forceStopO, m3invRotateO,
        output m3freqINCo, m3freqDECo, m3powerINCo, m3powerDECo
    );

endinterface

// File: rtl/m3_key_debounce.sv
// One push-button channel: 2-flop synchronizer, counting debouncer and
// press-event detector. held is the debounced "pressed" level; press is a
// one-cycle pulse on the debounced released->pressed transition.
module m3_key_debounce
    import m3_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic clkI,
    input  logic nRstI,
    input  logic key_raw,
    output logic held,
    output logic press
);

    localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYC);

    logic             sync1_q;
    logic             sync2_q;
    logic [1:0]       vld_q;
    logic             deb_q;
    logic [CNT_W-1:0] cnt_q;
    logic             armed_q;
    logic             press_q;
    logic             accept;
    logic             fall;

    // Debounced level takes the synchronized value on the last stable cycle
    assign accept = (sync2_q != deb_q) && (cnt_q == CNT_W'(DEBOUNCE_CYC - 1));
    assign fall   = accept && !sync2_q;

    // Synchronizer; vld_q marks when sync2_q holds sampled data rather than reset value
    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            vld_q   <= 2'b00;
        end else begin
            sync1_q <= key_raw;
            sync2_q <= sync1_q;
            vld_q   <= {vld_q[0], 1'b1};
        end
    end

    // Debounce counter: restarts on any bounce, saturates instead of wrapping
    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            deb_q <= 1'b1;
            cnt_q <= '0;
        end else if (sync2_q == deb_q) begin
            cnt_q <= '0;
        end else if (accept) begin
            deb_q <= sync2_q;
            cnt_q <= '0;
        end else if (cnt_q != CNT_W'(DEBOUNCE_CYC)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Press events are only armed once the key has been seen released after reset,
    // so a key held through reset never fires until it is pressed again
    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            armed_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            if (vld_q[1] && sync2_q) begin
                armed_q <= 1'b1;
            end
            press_q <= armed_q && fall;
        end
    end

    assign held  = !deb_q;
    assign press = press_q;

endmodule

// File: rtl/m3_key_cmd_gen.sv
// M3 key command generator: turns seven raw active-low push-buttons into
// registered motor commands (start pulse, force-stop level, direction toggle
// and four INC/DEC step pulses).
// Build option: define M3_KEY_AUTOREPEAT_EN to compile in the DELAY/REPEAT
// auto-repeat FSM for the INC/DEC keys; otherwise they pulse once per press.
module m3_key_cmd_gen
    import m3_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC  = DEF_DEBOUNCE_CYC,
    parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic             clkI,
    input  logic             nRstI,
    m3_key_cmd_gen_if.slave  key_if
);

    if (DEBOUNCE_CYC == 0 || REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_bad_cfg
        $error("m3_key_cmd_gen: timing parameters must be non-zero");
    end

    logic [NUM_KEYS-1:0] key_raw;
    logic [NUM_KEYS-1:0] key_held;
    logic [NUM_KEYS-1:0] key_press;

    assign key_raw = {key_if.keyPwrDnI, key_if.keyPwrUpI, key_if.keyFreqDnI,
                      key_if.keyFreqUpI, key_if.keyDirI, key_if.keyStopI, key_if.keyStartI};

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        m3_key_debounce #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
        ) u_deb (
            .clkI    (clkI),
            .nRstI   (nRstI),
            .key_raw (key_raw[k]),
            .held    (key_held[k]),
            .press   (key_press[k])
        );
    end

    logic                stop_held;
    logic [NUM_STEP-1:0] step_held;
    logic [NUM_STEP-1:0] step_press;
    logic [1:0]          pair_lock;
    logic [1:0]          pair_lock_q;
    logic [NUM_STEP-1:0] step_block;
    logic [NUM_STEP-1:0] step_trig;
    logic [NUM_STEP-1:0] step_pulse_d;
    logic [NUM_STEP-1:0] step_pulse_q;
    logic                start_q;
    logic                inv_q;

    assign stop_held  = key_held[KEY_STOP];
    assign step_held  = key_held[KEY_STEP0 +: NUM_STEP];
    assign step_press = key_press[KEY_STEP0 +: NUM_STEP];
    // Pair 0 = freqUp/freqDn, pair 1 = pwrUp/pwrDn
    assign pair_lock  = {step_held[3] & step_held[2], step_held[1] & step_held[0]};

    // Blocking and triggering per step channel; when a pair lock lifts, the key
    // still held counts as freshly pressed
    always_comb begin
        step_block = '0;
        step_trig  = '0;
        for (int i = 0; i < NUM_STEP; i++) begin
            step_block[i] = stop_held | pair_lock[i/2];
            step_trig[i]  = step_press[i]
                          | (pair_lock_q[i/2] & ~pair_lock[i/2] & step_held[i]);
        end
    end

`ifdef M3_KEY_AUTOREPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                     : REPEAT_PERIOD;
    localparam int unsigned RPT_W   = cnt_width(RPT_MAX);

    rpt_state_t          rpt_state_q [NUM_STEP];
    rpt_state_t          rpt_state_d [NUM_STEP];
    logic [RPT_W-1:0]    rpt_cnt_q   [NUM_STEP];
    logic [RPT_W-1:0]    rpt_cnt_d   [NUM_STEP];
    logic [NUM_STEP-1:0] rpt_tick;

    // Repeat FSM next state: release, stop or pair lock drop straight to IDLE
    always_comb begin
        rpt_tick = '0;
        for (int i = 0; i < NUM_STEP; i++) begin
            rpt_state_d[i] = rpt_state_q[i];
            rpt_cnt_d[i]   = rpt_cnt_q[i];
            if (step_block[i] || !step_held[i]) begin
                rpt_state_d[i] = RPT_IDLE;
                rpt_cnt_d[i]   = '0;
            end else begin
                case (rpt_state_q[i])
                    RPT_IDLE: begin
                        if (step_trig[i]) begin
                            rpt_state_d[i] = RPT_DELAY;
                            rpt_cnt_d[i]   = '0;
                        end
                    end
                    RPT_DELAY: begin
                        if (rpt_cnt_q[i] == RPT_W'(REPEAT_DELAY - 1)) begin
                            rpt_state_d[i] = RPT_REPEAT;
                            rpt_cnt_d[i]   = '0;
                        end else begin
                            rpt_cnt_d[i] = rpt_cnt_q[i] + 1'b1;
                        end
                    end
                    RPT_REPEAT: begin
                        if (rpt_cnt_q[i] == RPT_W'(REPEAT_PERIOD - 1)) begin
                            rpt_tick[i]  = 1'b1;
                            rpt_cnt_d[i] = '0;
                        end else begin
                            rpt_cnt_d[i] = rpt_cnt_q[i] + 1'b1;
                        end
                    end
                    default: begin
                        rpt_state_d[i] = RPT_IDLE;
                        rpt_cnt_d[i]   = '0;
                    end
                endcase
            end
        end
        step_pulse_d = ~step_block & step_held & (step_trig | rpt_tick);
    end

    // Repeat FSM state and counters
    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            for (int i = 0; i < NUM_STEP; i++) begin
                rpt_state_q[i] <= RPT_IDLE;
                rpt_cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_STEP; i++) begin
                rpt_state_q[i] <= rpt_state_d[i];
                rpt_cnt_q[i]   <= rpt_cnt_d[i];
            end
        end
    end
`else
    // Single pulse per press event
    always_comb begin
        step_pulse_d = ~step_block & step_held & step_trig;
    end
`endif

    // Registered command outputs and pair-lock history
    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            start_q      <= 1'b0;
            inv_q        <= 1'b0;
            step_pulse_q <= '0;
            pair_lock_q  <= '0;
        end else begin
            start_q      <= key_press[KEY_START] & ~stop_held;
            inv_q        <= inv_q ^ key_press[KEY_DIR];
            step_pulse_q <= step_pulse_d;
            pair_lock_q  <= pair_lock;
        end
    end

    assign key_if.m3startO     = start_q;
    assign key_if.m3forceStopO = stop_held;
    assign key_if.m3invRotateO = inv_q;
    assign key_if.m3freqINCo   = step_pulse_q[0];
    assign key_if.m3freqDECo   = step_pulse_q[1];
    assign key_if.m3powerINCo  = step_pulse_q[2];
    assign key_if.m3powerDECo  = step_pulse_q[3];

endmodule

// File: tb/tb_m3_key_cmd_gen.sv
// Directed bench for m3_key_cmd_gen with DEBOUNCE_CYC=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=5. Pulses are logged with their cycle number and compared
// against hand-computed counts and offsets.
module tb_m3_key_cmd_gen;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   c0, c1, c2;
    int   exp_pinc[$];

    typedef struct {
        int idx;
        int cyc;
    } ev_t;
    ev_t evq[$];

    m3_key_cmd_gen_if kif ();

    m3_key_cmd_gen #(
        .DEBOUNCE_CYC  (4),
        .REPEAT_DELAY  (10),
        .REPEAT_PERIOD (5)
    ) dut (
        .clkI   (clk),
        .nRstI  (rst_n),
        .key_if (kif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse index: 0 start, 1 freqINC, 2 freqDEC, 3 powerINC, 4 powerDEC
    logic [4:0] pulses;
    logic [6:0] outs;
    assign pulses = {kif.m3powerDECo, kif.m3powerINCo, kif.m3freqDECo, kif.m3freqINCo,
                     kif.m3startO};
    assign outs   = {kif.m3powerDECo, kif.m3powerINCo, kif.m3freqDECo, kif.m3freqINCo,
                     kif.m3invRotateO, kif.m3forceStopO, kif.m3startO};

    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 5; k++) begin
                if (pulses[k]) evq.push_back('{k, cyc});
            end
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    function automatic int count_ev(input int idx, input int from, input int upto);
        int n = 0;
        foreach (evq[j]) begin
            if (evq[j].idx == idx && evq[j].cyc >= from && evq[j].cyc <= upto) n++;
        end
        return n;
    endfunction

    function automatic int nth_ev(input int idx, input int from, input int nth);
        int n = 0;
        foreach (evq[j]) begin
            if (evq[j].idx == idx && evq[j].cyc >= from) begin
                if (n == nth) return evq[j].cyc;
                n++;
            end
        end
        return -1;
    endfunction

    initial begin
        kif.keyStartI  = 1'b1;
        kif.keyStopI   = 1'b1;
        kif.keyDirI    = 1'b1;
        kif.keyFreqUpI = 1'b1;
        kif.keyFreqDnI = 1'b1;
        kif.keyPwrUpI  = 1'b1;
        kif.keyPwrDnI  = 1'b1;

        // Reset state
        #1 rst_n = 1'b0;
        #1 check("rst_outs", int'(outs), 0);
        step(3);
        check("rst_outs_clk", int'(outs), 0);
        rst_n = 1'b1;
        step(5);
        check("idle_outs", int'(outs), 0);

        // Single press of freqUp held 20 cycles
        c0 = cyc;
        kif.keyFreqUpI = 1'b0;
        step(20);
        kif.keyFreqUpI = 1'b1;
        step(15);
`ifdef M3_KEY_AUTOREPEAT_EN
        check("finc_hold20_cnt", count_ev(1, c0, cyc), 2);
`else
        check("finc_hold20_cnt", count_ev(1, c0, cyc), 1);
`endif
        check("finc_latency", nth_ev(1, c0, 0) - c0, 7);
        check("fdec_quiet", count_ev(2, c0, cyc), 0);

        // Bouncing pwrDn never settles, then a clean press
        c0 = cyc;
        repeat (5) begin
            kif.keyPwrDnI = 1'b0;
            step(2);
            kif.keyPwrDnI = 1'b1;
            step(2);
        end
        step(12);
        check("pdec_bounce", count_ev(4, c0, cyc), 0);
        c1 = cyc;
        kif.keyPwrDnI = 1'b0;
        step(10);
        kif.keyPwrDnI = 1'b1;
        step(12);
        check("pdec_clean", count_ev(4, c1, cyc), 1);
        check("pdec_latency", nth_ev(4, c1, 0) - c1, 7);

        // pwrUp held 40 cycles
        c0 = cyc;
        kif.keyPwrUpI = 1'b0;
        step(40);
        kif.keyPwrUpI = 1'b1;
        step(20);
`ifdef M3_KEY_AUTOREPEAT_EN
        exp_pinc = '{7, 22, 27, 32, 37, 42};
`else
        exp_pinc = '{7};
`endif
        check("pinc_hold40_cnt", count_ev(3, c0, cyc), exp_pinc.size());
        foreach (exp_pinc[j]) check("pinc_hold40_cyc", nth_ev(3, c0, j) - c0, exp_pinc[j]);
        check("pinc_after_rel", count_ev(3, c0 + 43, cyc), 0);

        // freqUp + freqDn together, then release freqDn
        c0 = cyc;
        kif.keyFreqUpI = 1'b0;
        kif.keyFreqDnI = 1'b0;
        step(20);
        check("pair_finc", count_ev(1, c0, cyc), 0);
        check("pair_fdec", count_ev(2, c0, cyc), 0);
        c1 = cyc;
        kif.keyFreqDnI = 1'b1;
        step(10);
        kif.keyFreqUpI = 1'b1;
        step(15);
        check("pair_resume_cnt", count_ev(1, c1, cyc), 1);
        check("pair_resume_lat", nth_ev(1, c1, 0) - c1, 7);
        check("pair_resume_fdec", count_ev(2, c1, cyc), 0);

        // Start alone
        c0 = cyc;
        kif.keyStartI = 1'b0;
        step(10);
        kif.keyStartI = 1'b1;
        step(12);
        check("start_cnt", count_ev(0, c0, cyc), 1);
        check("start_latency", nth_ev(0, c0, 0) - c0, 7);

        // Stop held blocks start and power; dir still toggles
        c0 = cyc;
        kif.keyStopI = 1'b0;
        step(10);
        check("fstop_on", int'(kif.m3forceStopO), 1);
        kif.keyStartI = 1'b0;
        kif.keyPwrUpI = 1'b0;
        step(12);
        check("stop_start", count_ev(0, c0, cyc), 0);
        check("stop_pinc", count_ev(3, c0, cyc), 0);
        check("inv_init", int'(kif.m3invRotateO), 0);
        kif.keyDirI = 1'b0;
        step(8);
        kif.keyDirI = 1'b1;
        step(8);
        check("inv_first", int'(kif.m3invRotateO), 1);
        kif.keyDirI = 1'b0;
        step(8);
        kif.keyDirI = 1'b1;
        step(8);
        check("inv_second", int'(kif.m3invRotateO), 0);
        kif.keyStopI  = 1'b1;
        kif.keyStartI = 1'b1;
        kif.keyPwrUpI = 1'b1;
        step(12);
        check("fstop_off", int'(kif.m3forceStopO), 0);
        check("stop_start_all", count_ev(0, c0, cyc), 0);
        check("stop_pinc_all", count_ev(3, c0, cyc), 0);

        // Reset mid-repeat with pwrUp held
        kif.keyDirI = 1'b0;
        step(8);
        kif.keyDirI = 1'b1;
        step(8);
        check("inv_pre_rst", int'(kif.m3invRotateO), 1);
        kif.keyPwrUpI = 1'b0;
        step(25);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check("rst_async", int'(outs), 0);
        step(3);
        rst_n = 1'b1;
        c1 = cyc;
        step(30);
        check("held_thru_rst", count_ev(3, c1, cyc), 0);
        check("post_rst_outs", int'(outs), 0);
        kif.keyPwrUpI = 1'b1;
        step(10);
        c2 = cyc;
        kif.keyPwrUpI = 1'b0;
        step(10);
        kif.keyPwrUpI = 1'b1;
        step(12);
        check("repress_cnt", count_ev(3, c2, cyc), 1);
        check("repress_lat", nth_ev(3, c2, 0) - c2, 7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
